// File: rtl/load_store_unit_pkg.sv
// Shared types and store-lane helpers for the rv32i load/store unit.
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      LOAD_OP_LB,
      LOAD_OP_LH,
      LOAD_OP_LW,
      LOAD_OP_LBU,
      LOAD_OP_LHU
   } LoadOp_t;

   typedef enum logic [1:0] {
      STORE_OP_SB,
      STORE_OP_SH,
      STORE_OP_SW
   } StoreOp_t;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_WAIT,
      LSU_DONE
   } LsuState_t;

   function automatic logic [31:0] f_st_data(
      input StoreOp_t   op,
      input logic [31:0] wd
   );
      f_st_data = wd;
      unique case (op)
         STORE_OP_SB: f_st_data = {4{wd[7:0]}};
         STORE_OP_SH: f_st_data = {2{wd[15:0]}};
         default:     f_st_data = wd;
      endcase
   endfunction

   function automatic logic [3:0] f_st_strb(
      input StoreOp_t   op,
      input logic [1:0] lane
   );
      f_st_strb = 4'b1111;
      unique case (op)
         STORE_OP_SB: f_st_strb = 4'b0001 << lane;
         STORE_OP_SH: f_st_strb = lane[1] ? 4'b1100 : 4'b0011;
         default:     f_st_strb = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Valid/ready data-memory bus between the LSU and memory.
interface load_store_unit_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_align_extend.sv
// Picks the addressed byte/half of a read word and sign/zero-extends it.
module load_align_extend
   import load_store_unit_pkg::*;
(
   input  LoadOp_t     i_op,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
   assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

   always_comb begin
      o_data = i_rdata;
      unique case (i_op)
         LOAD_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
         LOAD_OP_LBU: o_data = {24'h0, w_byte};
         LOAD_OP_LH:  o_data = {{16{w_half[15]}}, w_half};
         LOAD_OP_LHU: o_data = {16'h0, w_half};
         default:     o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: issues one bus transaction per load/store and
// stalls the core until it completes or times out.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned CNT_W          = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_req,
   input  logic              MemWrite,
   input  LoadOp_t           LoadOp,
   input  StoreOp_t          StoreOp,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   load_store_unit_if.master bus,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              done,
   output logic              misaligned,
   output logic              bus_error
);

   LsuState_t        r_state;
   LsuState_t        w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_lane;
   LoadOp_t          r_op;
   logic             r_is_st;
   logic             r_valid;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic [31:0]      r_rdata;
   logic             r_berr;
   logic             w_issue;
   logic             w_limit;
   logic [31:0]      w_ext;

   always_comb begin
      misaligned = 1'b0;
      if (mem_req) begin
         if (MemWrite) begin
            unique case (StoreOp)
               STORE_OP_SH: misaligned = addr[0];
               STORE_OP_SW: misaligned = |addr[1:0];
               default:     misaligned = 1'b0;
            endcase
         end else begin
            unique case (LoadOp)
               LOAD_OP_LH,
               LOAD_OP_LHU: misaligned = addr[0];
               LOAD_OP_LW:  misaligned = |addr[1:0];
               default:     misaligned = 1'b0;
            endcase
         end
      end
   end

   assign w_issue = mem_req & ~misaligned;
   assign w_limit = (TIMEOUT_CYCLES != 0) &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= LSU_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         LSU_IDLE: if (w_issue) w_next = LSU_WAIT;
         LSU_WAIT: if (bus.mem_ready || w_limit) w_next = LSU_DONE;
         LSU_DONE: w_next = LSU_IDLE;
         default:  w_next = LSU_IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      unique case (r_state)
         LSU_IDLE: stall = w_issue;
         LSU_WAIT: stall = 1'b1;
         LSU_DONE: done  = 1'b1;
         default:  stall = 1'b0;
      endcase
   end

   load_align_extend u_ext (
      .i_op    (r_op),
      .i_lane  (r_lane),
      .i_rdata (bus.mem_rdata),
      .o_data  (w_ext)
   );

   // mem_ready wins over the timeout on the limit cycle
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_berr  <= 1'b0;
         r_cnt   <= '0;
         r_lane  <= '0;
         r_op    <= LOAD_OP_LB;
         r_is_st <= 1'b0;
      end else begin
         r_berr <= 1'b0;
         if (r_state == LSU_IDLE && w_issue) begin
            r_valid <= 1'b1;
            r_addr  <= {addr[31:2], 2'b00};
            r_wdata <= f_st_data(StoreOp, wdata);
            r_wstrb <= MemWrite ? f_st_strb(StoreOp, addr[1:0]) : 4'b0000;
            r_lane  <= addr[1:0];
            r_op    <= LoadOp;
            r_is_st <= MemWrite;
            r_cnt   <= '0;
         end else if (r_state == LSU_WAIT) begin
            if (bus.mem_ready) begin
               r_valid <= 1'b0;
               if (!r_is_st) r_rdata <= w_ext;
            end else if (w_limit) begin
               r_valid <= 1'b0;
               r_rdata <= '0;
               r_berr  <= 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.mem_valid = r_valid;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_wstrb = r_wstrb;
   assign rdata         = r_rdata;
   assign bus_error     = r_berr;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the control decoder in the single-cycle rv32i core.
- Consumes MemWrite, LoadOp and StoreOp plus the ALU-computed address and rs2 data.
- Drives a valid/ready data bus, aligns store data and byte strobes, and sign/zero-extends load data.
- Stalls the PC/register-file update until the bus transaction completes.

Parameters:
- TIMEOUT_CYCLES, 0, bus wait limit in cycles; 0 disables the timeout counter.
- CNT_W, 8, timeout counter width; TIMEOUT_CYCLES must fit in CNT_W bits.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- mem_req  in  1  current instruction is a load or store (decoded)
- MemWrite  in  1  1 = store, 0 = load
- LoadOp  in  LoadOp_t  LB/LH/LW/LBU/LHU select
- StoreOp  in  StoreOp_t  SB/SH/SW select
- addr  in  32  effective byte address
- wdata  in  32  rs2 store data
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  word-aligned bus address
- mem_wdata  out  32  lane-aligned store data
- mem_wstrb  out  4  byte strobes; 0000 for loads
- mem_rdata  in  32  bus read data
- rdata  out  32  extended load result, registered
- stall  out  1  hold PC and register-file write
- done  out  1  one-cycle retire pulse
- misaligned  out  1  combinational misalignment flag
- bus_error  out  1  one-cycle timeout pulse

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; mem_valid, mem_addr, mem_wdata, mem_wstrb, rdata, done, bus_error, counter all 0. Reset applies mid-transaction: mem_valid drops on that edge regardless of mem_ready.
- misaligned = mem_req & ((LH/LHU/SH & addr[0]) | (LW/SW & addr[1:0]!=0)).
  - A misaligned access never issues a bus request; stall=0, rdata unchanged.
  - Trap handling lives elsewhere.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on mem_req & !misaligned, go to WAIT. The same edge registers mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_wdata, mem_wstrb, and clears the counter.
  - WAIT: mem_valid=1, outputs held stable. On mem_ready, register extended rdata (loads only; stores leave rdata unchanged), clear mem_valid, go to DONE. mem_ready is accepted in the first WAIT cycle, giving minimum latency of 2 cycles from mem_req to done.
  - WAIT timeout (TIMEOUT_CYCLES>0): the counter increments each WAIT cycle without mem_ready. When counter==TIMEOUT_CYCLES-1 and mem_ready=0, clear mem_valid, rdata=0, bus_error=1 for one cycle, go to DONE. If mem_ready arrives on the limit cycle, it wins.
  - DONE: done=1, stall=0. Go to IDLE unconditionally, even though mem_req is still high for the retiring instruction, so no re-issue occurs.
- stall = (IDLE & mem_req & !misaligned) | WAIT. In DONE, stall=0.
- mem_ready while mem_valid=0 is ignored.
- Store alignment, with lane=addr[1:0]:
  - SB: wdata[7:0] replicated to all 4 bytes, wstrb=0001<<lane.
  - SH: wdata[15:0] replicated twice, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata unchanged, wstrb=1111.
- Load extension:
  - LB/LBU: byte mem_rdata[8*lane+:8], sign- or zero-extended to 32.
  - LH/LHU: half mem_rdata[16*addr[1]+:16], sign- or zero-extended.
  - LW: mem_rdata unchanged.
  - addr[1:0] is captured at issue for use in the extension.

Decomposition:
- riscv_defines.svh already holds LoadOp_t (LOAD_OP_LB, LH, LW, LBU, LHU) and StoreOp_t (STORE_OP_SB, SH, SW).
- Add LsuState_t (LSU_IDLE, LSU_WAIT, LSU_DONE) to riscv_defines.svh.
- One combinational sub-module, load_align_extend (LoadOp, lane, mem_rdata -> extended word), reused by the multicycle edition.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready 1 cycle after valid -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall 2 cycles; done pulse on 3rd cycle; rdata unchanged.
- SB addr=0x103, wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5. SH addr=0x102 -> wstrb=1100.
- mem_rdata=0x80FF7F01: LB at lane 3 -> 0xFFFFFF80; LBU lane 3 -> 0x00000080; LH addr[1]=1 -> 0xFFFF80FF; LHU addr[1]=0 -> 0x00007F01.
- LW addr=0x102 -> misaligned=1, mem_valid never asserts, stall=0, no done pulse.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high exactly 4 cycles, then bus_error=1, done=1, rdata=0. Repeat with mem_ready on the 4th cycle -> normal completion, bus_error=0.
- resetn=0 during WAIT -> next edge mem_valid=0, state IDLE, stall tracks mem_req. A late mem_ready after reset produces no done pulse.
